// File: rtl/apb_master.sv
// APB initiator: turns single-beat local commands into SETUP/ACCESS
// transfers and returns a one-cycle response (read data or timeout).
module apb_master #(
    parameter int BITWIDTH  = 8,
    parameter int ADDRWIDTH = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDRWIDTH-1:0] cmd_addr,
    input  logic [BITWIDTH-1:0]  cmd_wdata,
    output logic                 rsp_valid,
    output logic                 rsp_err,
    output logic [BITWIDTH-1:0]  rsp_rdata,
    output logic                 psel,
    output logic                 penable,
    output logic [ADDRWIDTH-1:0] paddr,
    output logic                 pwrite,
    output logic [BITWIDTH-1:0]  pwdata,
    input  logic [BITWIDTH-1:0]  prdata,
    input  logic                 pready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    localparam logic [7:0] LP_TLAST = 8'(TIMEOUT - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_cmd_ready;
    logic                  r_psel;
    logic                  r_penable;
    logic [ADDRWIDTH-1:0]  r_paddr;
    logic                  r_pwrite;
    logic [BITWIDTH-1:0]   r_pwdata;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic [BITWIDTH-1:0]   r_rsp_rdata;
    logic [7:0]            r_cnt;

    logic [ADDRWIDTH-1:0]  w_paddr;
    logic                  w_pwrite;
    logic [BITWIDTH-1:0]   w_pwdata;
    logic                  w_rsp_valid;
    logic                  w_rsp_err;
    logic [BITWIDTH-1:0]   w_rsp_rdata;
    logic [7:0]            w_cnt;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_paddr     = r_paddr;
        w_pwrite    = r_pwrite;
        w_pwdata    = r_pwdata;
        w_rsp_valid = 1'b0;
        w_rsp_err   = 1'b0;
        w_rsp_rdata = r_rsp_rdata;
        w_cnt       = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_paddr     = cmd_addr;
                    w_pwrite    = cmd_write;
                    w_pwdata    = cmd_wdata;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_cnt       = 8'd0;
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A ready slave wins over an expiring wait budget.
                if (pready) begin
                    w_state_nxt = ST_IDLE;
                    w_rsp_valid = 1'b1;
                    if (!r_pwrite) begin
                        w_rsp_rdata = prdata;
                    end
                end else if (r_cnt == LP_TLAST) begin
                    w_state_nxt = ST_IDLE;
                    w_rsp_valid = 1'b1;
                    w_rsp_err   = 1'b1;
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_cmd_ready <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_cnt       <= 8'd0;
        end else begin
            r_cmd_ready <= (w_state_nxt == ST_IDLE);
            r_psel      <= (w_state_nxt != ST_IDLE);
            r_penable   <= (w_state_nxt == ST_ACCESS);
            r_paddr     <= w_paddr;
            r_pwrite    <= w_pwrite;
            r_pwdata    <= w_pwdata;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_err   <= w_rsp_err;
            r_rsp_rdata <= w_rsp_rdata;
            r_cnt       <= w_cnt;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign paddr     = r_paddr;
    assign pwrite    = r_pwrite;
    assign pwdata    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule
